fmps_packet_collector: RTL
==========================

// Module: fmps_packet_collector
// PURPOSE
//  Consumer stage directly downstream of axisMux. Takes the merged FMPS AXI-stream (header word + data words),
//  checks each packet's framing and magic, and stores the payload per FMPS index in a register bank.
//  Tracks which indices arrived in the current FA cycle and strobes once all NUM_INDICES have been seen.
//  Feeds the cell-controller processing logic, which reads the bank after cycleCompleteStrobe.
// PARAMETERS
//  DATA_WIDTH      32  width of s_data / one data word
//  USER_WIDTH      1   width of s_user (accepted, ignored)
//  MAGIC_WIDTH     16  header magic field width
//  MAGIC_START_BIT 16  LSB of magic field in header word
//  INDEX_WIDTH     5   header index field width
//  INDEX_START_BIT 10  LSB of index field in header word
//  NUM_DATA_WORDS  1   data words following the header (>=1)
//  NUM_INDICES     16  number of valid indices per cycle (<= 2**INDEX_WIDTH)
// PORTS
//  clk                 in   1                        stream clock
//  rst                 in   1                        synchronous, active-high reset
//  newCycleStrobe      in   1                        FA cycle start; clears arrival map and counters
//  expectedHeaderMagic in   MAGIC_WIDTH              magic required in header
//  s_valid/s_ready     in/out 1                      AXI-stream handshake from axisMux
//  s_last              in   1                        end of packet
//  s_data              in   DATA_WIDTH               stream word
//  s_user              in   USER_WIDTH               ignored
//  statusStrobe        out  1                        one-cycle pulse at each packet end
//  statusCode          out  2                        0 OK, 1 BAD_MAGIC, 2 BAD_SIZE, 3 BAD_INDEX
//  packetStrobe        out  1                        pulse with a valid, stored packet
//  packetIndex         out  INDEX_WIDTH              index of last OK packet
//  packetData          out  DATA_WIDTH*NUM_DATA_WORDS payload of last OK packet (word 0 in LSBs)
//  validMap            out  NUM_INDICES              bit i set if index i received this cycle
//  cycleCompleteStrobe out  1                        pulse when validMap first becomes all ones in a cycle
//  packetCount         out  16                       OK packets this cycle, saturating
//  errorCount          out  16                       bad packets since reset, saturating
//  rdAddr              in   INDEX_WIDTH              bank read address
//  rdData              out  DATA_WIDTH*NUM_DATA_WORDS bank read data, 1-cycle latency
// BEHAVIOUR
//  - Reset: state HEADER, s_ready=0 during rst and 1 afterwards; all strobes, codes, maps and counters are 0;
//    rdData=0. Bank contents are not cleared.
//  - Beat = s_valid & s_ready. s_ready=1 in every state outside reset (no backpressure).
//  - FSM HEADER: on beat, latch the index and compare the magic.
//    - s_last set -> BAD_SIZE, stay in HEADER.
//    - Magic mismatch -> BAD_MAGIC, go to DRAIN.
//    - Index >= NUM_INDICES -> BAD_INDEX, go to DRAIN.
//    - Otherwise wordCnt=0, go to DATA.
//  - FSM DATA: each beat shifts the word into the capture register at slot wordCnt.
//    - s_last before word NUM_DATA_WORDS-1 -> BAD_SIZE, go to HEADER.
//    - Final word with s_last -> OK, go to HEADER.
//    - Final word without s_last -> BAD_SIZE, go to DRAIN.
//  - FSM DRAIN: discard beats until s_last, then go to HEADER (no extra status).
//  - Status and packet outputs are registered: statusStrobe/packetStrobe are high the cycle after the terminating beat.
//    packetIndex and packetData hold until the next OK packet.
//  - On OK: bank[index] is written, validMap[index] is set and packetCount is incremented.
//    A duplicate index overwrites the bank entry; packetCount still increments.
//  - On a non-OK status, errorCount is incremented (saturates at 16'hFFFF).
//  - newCycleStrobe clears validMap, packetCount and the complete flag in the same edge.
//    An OK completion on the same edge survives: validMap = only that bit, packetCount = 1.
//    A packet in flight is not aborted.
//  - cycleCompleteStrobe fires once per cycle, on the edge after validMap becomes all ones.
//  - Read port: rdData <= bank[rdAddr]. Reading the address being written on the same edge returns the old data.
//    rdAddr >= NUM_INDICES returns 0.
//  - rst mid-packet: the partial packet is dropped with no status, and the FSM returns to HEADER.
// STRUCTURE
//  - Package fmps_pkg: statusCode constants (ST_OK/BAD_MAGIC/BAD_SIZE/BAD_INDEX), FSM state encoding,
//    field-extract localparams shared with the mux and packet generators.
//  - One sub-module, fmps_packet_bank: NUM_INDICES x payload register bank, one write port, registered read.
//  - The FSM, counters and map live in the top module.
// TESTING
//  1. Reset, magic 16'hB6CF: 16 packets, indices 0..15, data 32'h00CACA01 ->
//     16 OK strobes, validMap=16'hFFFF, one cycleCompleteStrobe, packetCount=16.
//  2. Header with magic 16'hDEAD, then 1 data word ->
//     statusCode=1, DRAIN consumes the data word, errorCount=1, validMap unchanged.
//  3. Header with s_last set, then a valid packet with index 3 ->
//     BAD_SIZE, then OK, validMap=16'h0008.
//  4. Index 20 with NUM_INDICES=16 -> statusCode=3, bank unchanged.
//     Then rdAddr=20 -> rdData=0.
//  5. newCycleStrobe on the same edge as the OK completion of index 5 ->
//     validMap=16'h0020, packetCount=1.
//  6. Random s_valid gaps, rst asserted mid-DATA ->
//     no status strobe, next clean packet OK.
//     rdData for the written index matches the payload 1 cycle after rdAddr.

Source files
------------

// File: rtl/fmps_pkg.sv
// Shared FMPS definitions: status codes, collector FSM states, header field
// defaults and a saturating counter helper.
package fmps_pkg;

    localparam int unsigned STATUS_W = 2;
    localparam int unsigned COUNT_W  = 16;

    localparam logic [STATUS_W-1:0] ST_OK        = 2'd0;
    localparam logic [STATUS_W-1:0] ST_BAD_MAGIC = 2'd1;
    localparam logic [STATUS_W-1:0] ST_BAD_SIZE  = 2'd2;
    localparam logic [STATUS_W-1:0] ST_BAD_INDEX = 2'd3;

    typedef enum logic [1:0] {
        S_HEADER = 2'd0,
        S_DATA   = 2'd1,
        S_DRAIN  = 2'd2
    } fmps_state_t;

    // Header layout shared with the mux and packet generators
    localparam int unsigned FMPS_DATA_WIDTH      = 32;
    localparam int unsigned FMPS_MAGIC_WIDTH     = 16;
    localparam int unsigned FMPS_MAGIC_START_BIT = 16;
    localparam int unsigned FMPS_INDEX_WIDTH     = 5;
    localparam int unsigned FMPS_INDEX_START_BIT = 10;

    // Increment that sticks at all-ones
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/fmps_packet_collector_if.sv
// AXI-stream bundle between axisMux (master) and the packet collector (slave).
//   s_valid/s_ready : handshake
//   s_last          : end of packet
//   s_data          : stream word
//   s_user          : sideband, carried but unused by the collector
interface fmps_packet_collector_if #(
    parameter int unsigned DATA_WIDTH = fmps_pkg::FMPS_DATA_WIDTH,
    parameter int unsigned USER_WIDTH = 1
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic                  s_last;
    logic [DATA_WIDTH-1:0] s_data;
    logic [USER_WIDTH-1:0] s_user;

    modport master (output s_valid, s_last, s_data, s_user, input s_ready);
    modport slave  (input s_valid, s_last, s_data, s_user, output s_ready);
endinterface

// File: rtl/fmps_packet_bank.sv
// Per-index payload store: NUM_INDICES entries, one write port, registered read.
//   clk, rst      : clock, synchronous active-high reset (read register only)
//   wr_en_i       : write enable
//   wr_addr_i     : write index
//   wr_data_i     : write payload
//   rd_addr_i     : read index; out-of-range reads return 0
//   rd_data_o     : read payload, one cycle after rd_addr_i
module fmps_packet_bank #(
    parameter int unsigned PAYLOAD_W   = 32,
    parameter int unsigned NUM_INDICES = 16,
    parameter int unsigned INDEX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [INDEX_WIDTH-1:0] wr_addr_i,
    input  logic [PAYLOAD_W-1:0]   wr_data_i,
    input  logic [INDEX_WIDTH-1:0] rd_addr_i,
    output logic [PAYLOAD_W-1:0]   rd_data_o
);

    logic [PAYLOAD_W-1:0] mem_q [NUM_INDICES];
    logic [PAYLOAD_W-1:0] rd_data_d;
    logic [PAYLOAD_W-1:0] rd_data_q;

    // Address decode by compare keeps the index width independent of the depth
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < int'(NUM_INDICES); i++) begin
            if (rd_addr_i == INDEX_WIDTH'(i)) begin
                rd_data_d = mem_q[i];
            end
        end
    end

    // Storage is not reset; a same-edge read sees the old entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_INDICES); i++) begin
            if (wr_en_i && (wr_addr_i == INDEX_WIDTH'(i))) begin
                mem_q[i] <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fmps_packet_collector.sv
// Collects FMPS packets from the merged stream, validates framing/magic/index,
// stores OK payloads per index and tracks per-FA-cycle arrival.
//   clk, rst             : clock, synchronous active-high reset
//   newCycleStrobe       : FA cycle start, clears map/count/complete flag
//   expectedHeaderMagic  : magic required in each header
//   s_axis               : stream slave (never backpressures outside reset)
//   statusStrobe/Code    : pulse + code at each terminating beat
//   packetStrobe/Index/Data : last OK packet
//   validMap             : indices received this cycle
//   cycleCompleteStrobe  : once per cycle when validMap goes all ones
//   packetCount          : OK packets this cycle (saturating)
//   errorCount           : bad packets since reset (saturating)
//   rdAddr/rdData        : bank read port, 1-cycle latency
module fmps_packet_collector
    import fmps_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = FMPS_DATA_WIDTH,
    parameter int unsigned USER_WIDTH      = 1,
    parameter int unsigned MAGIC_WIDTH     = FMPS_MAGIC_WIDTH,
    parameter int unsigned MAGIC_START_BIT = FMPS_MAGIC_START_BIT,
    parameter int unsigned INDEX_WIDTH     = FMPS_INDEX_WIDTH,
    parameter int unsigned INDEX_START_BIT = FMPS_INDEX_START_BIT,
    parameter int unsigned NUM_DATA_WORDS  = 1,
    parameter int unsigned NUM_INDICES     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 newCycleStrobe,
    input  logic [MAGIC_WIDTH-1:0]               expectedHeaderMagic,
    fmps_packet_collector_if.slave               s_axis,
    output logic                                 statusStrobe,
    output logic [STATUS_W-1:0]                  statusCode,
    output logic                                 packetStrobe,
    output logic [INDEX_WIDTH-1:0]               packetIndex,
    output logic [DATA_WIDTH*NUM_DATA_WORDS-1:0] packetData,
    output logic [NUM_INDICES-1:0]               validMap,
    output logic                                 cycleCompleteStrobe,
    output logic [COUNT_W-1:0]                   packetCount,
    output logic [COUNT_W-1:0]                   errorCount,
    input  logic [INDEX_WIDTH-1:0]               rdAddr,
    output logic [DATA_WIDTH*NUM_DATA_WORDS-1:0] rdData
);

    localparam int unsigned PAYLOAD_W = DATA_WIDTH * NUM_DATA_WORDS;
    localparam int unsigned CNT_W     = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_DATA_WORDS - 1);

    fmps_state_t              state_q;
    logic                     s_ready_q;
    logic [CNT_W-1:0]         word_cnt_q;
    logic [INDEX_WIDTH-1:0]   idx_q;
    logic [PAYLOAD_W-1:0]     cap_q;
    logic                     status_strobe_q;
    logic [STATUS_W-1:0]      status_code_q;
    logic                     packet_strobe_q;
    logic [INDEX_WIDTH-1:0]   packet_index_q;
    logic [PAYLOAD_W-1:0]     packet_data_q;
    logic [NUM_INDICES-1:0]   valid_map_q;
    logic                     complete_q;
    logic                     cycle_complete_q;
    logic [COUNT_W-1:0]       packet_count_q;
    logic [COUNT_W-1:0]       error_count_q;

    logic                     beat_c;
    logic [MAGIC_WIDTH-1:0]   hdr_magic_c;
    logic [INDEX_WIDTH-1:0]   hdr_idx_c;
    logic                     idx_oob_c;
    logic [PAYLOAD_W-1:0]     cap_c;
    logic [NUM_INDICES-1:0]   idx_onehot_c;
    logic [USER_WIDTH-1:0]    unused_user;

    assign beat_c      = s_axis.s_valid & s_ready_q;
    assign hdr_magic_c = s_axis.s_data[MAGIC_START_BIT +: MAGIC_WIDTH];
    assign hdr_idx_c   = s_axis.s_data[INDEX_START_BIT +: INDEX_WIDTH];
    assign idx_oob_c   = 32'(hdr_idx_c) >= 32'(NUM_INDICES);
    assign unused_user = s_axis.s_user;

    // Capture register with the current beat dropped into slot word_cnt_q
    always_comb begin
        cap_c = cap_q;
        for (int w = 0; w < int'(NUM_DATA_WORDS); w++) begin
            if (word_cnt_q == CNT_W'(w)) begin
                cap_c[w*DATA_WIDTH +: DATA_WIDTH] = s_axis.s_data;
            end
        end
    end

    always_comb begin
        idx_onehot_c = '0;
        for (int i = 0; i < int'(NUM_INDICES); i++) begin
            if (idx_q == INDEX_WIDTH'(i)) begin
                idx_onehot_c[i] = 1'b1;
            end
        end
    end

    // Framing FSM with registered status, map and counters. Later assignments
    // in the block override the newCycleStrobe clear so a same-edge OK survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_HEADER;
            s_ready_q        <= 1'b0;
            word_cnt_q       <= '0;
            idx_q            <= '0;
            cap_q            <= '0;
            status_strobe_q  <= 1'b0;
            status_code_q    <= ST_OK;
            packet_strobe_q  <= 1'b0;
            packet_index_q   <= '0;
            packet_data_q    <= '0;
            valid_map_q      <= '0;
            complete_q       <= 1'b0;
            cycle_complete_q <= 1'b0;
            packet_count_q   <= '0;
            error_count_q    <= '0;
        end else begin
            s_ready_q        <= 1'b1;
            status_strobe_q  <= 1'b0;
            packet_strobe_q  <= 1'b0;
            cycle_complete_q <= 1'b0;

            if (newCycleStrobe) begin
                valid_map_q    <= '0;
                packet_count_q <= '0;
                complete_q     <= 1'b0;
            end else if (!complete_q && (&valid_map_q)) begin
                cycle_complete_q <= 1'b1;
                complete_q       <= 1'b1;
            end

            if (beat_c) begin
                unique case (state_q)
                    S_HEADER: begin
                        idx_q <= hdr_idx_c;
                        if (s_axis.s_last) begin
                            status_strobe_q <= 1'b1;
                            status_code_q   <= ST_BAD_SIZE;
                            error_count_q   <= sat_inc(error_count_q);
                        end else if (hdr_magic_c != expectedHeaderMagic) begin
                            status_strobe_q <= 1'b1;
                            status_code_q   <= ST_BAD_MAGIC;
                            error_count_q   <= sat_inc(error_count_q);
                            state_q         <= S_DRAIN;
                        end else if (idx_oob_c) begin
                            status_strobe_q <= 1'b1;
                            status_code_q   <= ST_BAD_INDEX;
                            error_count_q   <= sat_inc(error_count_q);
                            state_q         <= S_DRAIN;
                        end else begin
                            word_cnt_q <= '0;
                            state_q    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        cap_q <= cap_c;
                        if (word_cnt_q == LAST_WORD) begin
                            status_strobe_q <= 1'b1;
                            if (s_axis.s_last) begin
                                status_code_q   <= ST_OK;
                                packet_strobe_q <= 1'b1;
                                packet_index_q  <= idx_q;
                                packet_data_q   <= cap_c;
                                valid_map_q     <= (newCycleStrobe ? '0 : valid_map_q) | idx_onehot_c;
                                packet_count_q  <= newCycleStrobe ? COUNT_W'(1) : sat_inc(packet_count_q);
                                state_q         <= S_HEADER;
                            end else begin
                                status_code_q <= ST_BAD_SIZE;
                                error_count_q <= sat_inc(error_count_q);
                                state_q       <= S_DRAIN;
                            end
                        end else if (s_axis.s_last) begin
                            status_strobe_q <= 1'b1;
                            status_code_q   <= ST_BAD_SIZE;
                            error_count_q   <= sat_inc(error_count_q);
                            state_q         <= S_HEADER;
                        end else begin
                            word_cnt_q <= word_cnt_q + CNT_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (s_axis.s_last) begin
                            state_q <= S_HEADER;
                        end
                    end
                    default: state_q <= S_HEADER;
                endcase
            end
        end
    end

    // Bank is written from the registered OK packet, one edge after completion
    fmps_packet_bank #(
        .PAYLOAD_W   (PAYLOAD_W),
        .NUM_INDICES (NUM_INDICES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (packet_strobe_q),
        .wr_addr_i (packet_index_q),
        .wr_data_i (packet_data_q),
        .rd_addr_i (rdAddr),
        .rd_data_o (rdData)
    );

    assign s_axis.s_ready      = s_ready_q;
    assign statusStrobe        = status_strobe_q;
    assign statusCode          = status_code_q;
    assign packetStrobe        = packet_strobe_q;
    assign packetIndex         = packet_index_q;
    assign packetData          = packet_data_q;
    assign validMap            = valid_map_q;
    assign cycleCompleteStrobe = cycle_complete_q;
    assign packetCount         = packet_count_q;
    assign errorCount          = error_count_q;

endmodule
